// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute pipeline stage with one-hot ALU, data SRAM request and bypass outputs

// One-hot ALU: each alu_op bit selects one operation; results are OR-combined.
module alu (
  input  logic [11:0] i_alu_op,
  input  logic [31:0] i_alu_src1,
  input  logic [31:0] i_alu_src2,
  output logic [31:0] o_alu_result
);

  logic        w_op_add;
  logic        w_op_sub;
  logic        w_op_slt;
  logic        w_op_sltu;
  logic        w_op_and;
  logic        w_op_nor;
  logic        w_op_or;
  logic        w_op_xor;
  logic        w_op_sll;
  logic        w_op_srl;
  logic        w_op_sra;
  logic        w_op_lui;

  logic [31:0] w_add_result;
  logic [31:0] w_sub_result;
  logic [31:0] w_slt_result;
  logic [31:0] w_sltu_result;
  logic [31:0] w_and_result;
  logic [31:0] w_nor_result;
  logic [31:0] w_or_result;
  logic [31:0] w_xor_result;
  logic [31:0] w_sll_result;
  logic [31:0] w_srl_result;
  logic [31:0] w_sra_result;
  logic [31:0] w_lui_result;
  logic [4:0]  w_shamt;

  assign w_op_add  = i_alu_op[0];
  assign w_op_sub  = i_alu_op[1];
  assign w_op_slt  = i_alu_op[2];
  assign w_op_sltu = i_alu_op[3];
  assign w_op_and  = i_alu_op[4];
  assign w_op_nor  = i_alu_op[5];
  assign w_op_or   = i_alu_op[6];
  assign w_op_xor  = i_alu_op[7];
  assign w_op_sll  = i_alu_op[8];
  assign w_op_srl  = i_alu_op[9];
  assign w_op_sra  = i_alu_op[10];
  assign w_op_lui  = i_alu_op[11];

  // Shift amount is the low five bits of the second operand.
  assign w_shamt = i_alu_src2[4:0];

  assign w_add_result  = i_alu_src1 + i_alu_src2;
  assign w_sub_result  = i_alu_src1 - i_alu_src2;
  assign w_slt_result  = {31'd0, ($signed(i_alu_src1) < $signed(i_alu_src2))};
  assign w_sltu_result = {31'd0, (i_alu_src1 < i_alu_src2)};
  assign w_and_result  = i_alu_src1 & i_alu_src2;
  assign w_nor_result  = ~(i_alu_src1 | i_alu_src2);
  assign w_or_result   = i_alu_src1 | i_alu_src2;
  assign w_xor_result  = i_alu_src1 ^ i_alu_src2;
  assign w_sll_result  = i_alu_src1 << w_shamt;
  assign w_srl_result  = i_alu_src1 >> w_shamt;
  assign w_sra_result  = 32'($signed(i_alu_src1) >>> w_shamt);
  // lui-style op: the immediate arrives pre-shifted on src2.
  assign w_lui_result  = i_alu_src2;

  assign o_alu_result = ({32{w_op_add }} & w_add_result )
                      | ({32{w_op_sub }} & w_sub_result )
                      | ({32{w_op_slt }} & w_slt_result )
                      | ({32{w_op_sltu}} & w_sltu_result)
                      | ({32{w_op_and }} & w_and_result )
                      | ({32{w_op_nor }} & w_nor_result )
                      | ({32{w_op_or  }} & w_or_result  )
                      | ({32{w_op_xor }} & w_xor_result )
                      | ({32{w_op_sll }} & w_sll_result )
                      | ({32{w_op_srl }} & w_srl_result )
                      | ({32{w_op_sra }} & w_sra_result )
                      | ({32{w_op_lui }} & w_lui_result );

endmodule

// Execute stage: one-entry pipeline slot between ID and MEM.
module exe_stage #(
  parameter int DS_TO_ES_W = 148,
  parameter int ES_TO_MS_W = 71
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ms_allowin,
  output logic                  es_allowin,
  input  logic                  ds_to_es_valid,
  input  logic [DS_TO_ES_W-1:0] ds_to_es_bus,
  output logic                  es_to_ms_valid,
  output logic [ES_TO_MS_W-1:0] es_to_ms_bus,
  output logic                  data_sram_en,
  output logic [3:0]            data_sram_we,
  output logic [31:0]           data_sram_addr,
  output logic [31:0]           data_sram_wdata,
  output logic                  es_fwd_valid,
  output logic [4:0]            es_fwd_dest,
  output logic [31:0]           es_fwd_data,
  output logic                  es_ld_blk
);

  logic                  r_es_valid;
  logic [DS_TO_ES_W-1:0] r_es_bus;

  logic                  w_es_ready_go;
  logic                  w_es_load;

  logic [11:0]           w_alu_op;
  logic                  w_res_from_mem;
  logic                  w_mem_we;
  logic                  w_gr_we;
  logic [4:0]            w_dest;
  logic [31:0]           w_alu_src1;
  logic [31:0]           w_alu_src2;
  logic [31:0]           w_rkd_value;
  logic [31:0]           w_pc;
  logic [31:0]           w_alu_result;

  // Execute always completes in one cycle, so the stage never holds itself.
  assign w_es_ready_go  = 1'b1;
  assign es_allowin     = !r_es_valid || (w_es_ready_go && ms_allowin);
  assign es_to_ms_valid = r_es_valid && w_es_ready_go;

  // Payload is captured only for a real instruction; bubbles leave it untouched.
  assign w_es_load = ds_to_es_valid && es_allowin;

  // Slot valid flag: follows the ID valid whenever the slot can accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_es_valid <= 1'b0;
    end else if (es_allowin) begin
      r_es_valid <= ds_to_es_valid;
    end
  end

  // Slot payload: loads on accepted instructions, holds on stalls and bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_es_bus <= '0;
    end else if (w_es_load) begin
      r_es_bus <= ds_to_es_bus;
    end
  end

  // Field order matches the ID-side packing, MSB first.
  assign w_alu_op       = r_es_bus[147:136];
  assign w_res_from_mem = r_es_bus[135];
  assign w_mem_we       = r_es_bus[134];
  assign w_gr_we        = r_es_bus[133];
  assign w_dest         = r_es_bus[132:128];
  assign w_alu_src1     = r_es_bus[127:96];
  assign w_alu_src2     = r_es_bus[95:64];
  assign w_rkd_value    = r_es_bus[63:32];
  assign w_pc           = r_es_bus[31:0];

  alu u_alu (
    .i_alu_op     (w_alu_op),
    .i_alu_src1   (w_alu_src1),
    .i_alu_src2   (w_alu_src2),
    .o_alu_result (w_alu_result)
  );

  assign es_to_ms_bus = {w_res_from_mem, w_gr_we, w_dest, w_alu_result, w_pc};

  // Strobes are gated by ms_allowin so a store stalled by MEM writes exactly once,
  // in the cycle it advances.
  assign data_sram_en    = r_es_valid && (w_res_from_mem || w_mem_we);
  assign data_sram_we    = {4{r_es_valid && w_mem_we && ms_allowin}};
  assign data_sram_addr  = w_alu_result;
  assign data_sram_wdata = w_rkd_value;

  // Bypass and load-use hazard information for the ID stage.
  assign es_fwd_valid = r_es_valid && w_gr_we;
  assign es_fwd_dest  = w_dest;
  assign es_fwd_data  = w_alu_result;
  assign es_ld_blk    = r_es_valid && w_res_from_mem;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - self-checking bench for exe_stage with a behavioural slot model
module tb_exe_stage;

  typedef struct packed {
    logic [11:0] op;
    logic        rfm;
    logic        mwe;
    logic        grwe;
    logic [4:0]  dest;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] rkd;
    logic [31:0] pc;
  } instr_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ms_allowin = 1'b1;
  logic         es_allowin;
  logic         ds_to_es_valid = 1'b0;
  logic [147:0] ds_to_es_bus = '0;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         es_fwd_valid;
  logic [4:0]   es_fwd_dest;
  logic [31:0]  es_fwd_data;
  logic         es_ld_blk;

  int n_checks = 0;
  int n_pass = 0;

  exe_stage #(.DS_TO_ES_W(148), .ES_TO_MS_W(71)) dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .es_fwd_valid    (es_fwd_valid),
    .es_fwd_dest     (es_fwd_dest),
    .es_fwd_data     (es_fwd_data),
    .es_ld_blk       (es_ld_blk)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(input logic [11:0] op, input logic rfm, input logic mwe,
                                input logic grwe, input logic [4:0] dest,
                                input logic [31:0] s1, input logic [31:0] s2,
                                input logic [31:0] rkd, input logic [31:0] pc);
    instr_t t;
    t.op = op; t.rfm = rfm; t.mwe = mwe; t.grwe = grwe; t.dest = dest;
    t.s1 = s1; t.s2 = s2; t.rkd = rkd; t.pc = pc;
    return t;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (op)
      12'h001: return a + b;
      12'h002: return a - b;
      12'h004: return (sa < sb) ? 32'd1 : 32'd0;
      12'h008: return (a < b) ? 32'd1 : 32'd0;
      12'h010: return a & b;
      12'h020: return ~(a | b);
      12'h040: return a | b;
      12'h080: return a ^ b;
      12'h100: return a << b[4:0];
      12'h200: return a >> b[4:0];
      12'h400: return 32'(sa >>> b[4:0]);
      12'h800: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [70:0] ms_ref(input instr_t t);
    return {t.rfm, t.grwe, t.dest, alu_ref(t.op, t.s1, t.s2), t.pc};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = mk(12'h001, 1'b1, 1'b1, 1'b1, 5'd1, 32'd1, 32'd1, 32'd1, 32'd0);
    ms_allowin = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (es_to_ms_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", es_to_ms_valid); else n_pass++;
    n_checks++;
    if (es_allowin !== 1'b1) $display("FAIL rst_allowin got %0b exp 1", es_allowin); else n_pass++;
    n_checks++;
    if (data_sram_en !== 1'b0 || data_sram_we !== 4'h0)
      $display("FAIL rst_sram got en=%0b we=%h exp en=0 we=0", data_sram_en, data_sram_we);
    else n_pass++;
    n_checks++;
    if (es_fwd_valid !== 1'b0 || es_ld_blk !== 1'b0)
      $display("FAIL rst_fwd got fwd=%0b ldblk=%0b exp 0 0", es_fwd_valid, es_ld_blk);
    else n_pass++;
    ds_to_es_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (es_to_ms_valid !== 1'b0 || es_allowin !== 1'b1)
      $display("FAIL post_rst got valid=%0b allowin=%0b exp 0 1", es_to_ms_valid, es_allowin);
    else n_pass++;
  endtask

  task automatic test_add();
    instr_t t;
    t = mk(12'h001, 1'b0, 1'b0, 1'b1, 5'd3, 32'd5, 32'd7, 32'd0, 32'h1c00_0000);
    @(negedge clk);
    ds_to_es_valid = 1'b1; ds_to_es_bus = t; ms_allowin = 1'b1;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    n_checks++;
    if (es_to_ms_valid !== 1'b1) $display("FAIL add_valid got %0b exp 1", es_to_ms_valid); else n_pass++;
    n_checks++;
    if (es_to_ms_bus[63:32] !== 32'd12) $display("FAIL add_result got %0d exp 12", es_to_ms_bus[63:32]); else n_pass++;
    n_checks++;
    if (es_fwd_valid !== 1'b1 || es_fwd_dest !== 5'd3 || es_fwd_data !== 32'd12)
      $display("FAIL add_fwd got v=%0b d=%0d data=%0d exp 1 3 12", es_fwd_valid, es_fwd_dest, es_fwd_data);
    else n_pass++;
    n_checks++;
    if (es_to_ms_bus !== {1'b0, 1'b1, 5'd3, 32'd12, 32'h1c00_0000})
      $display("FAIL add_bus got %h exp %h", es_to_ms_bus, {1'b0, 1'b1, 5'd3, 32'd12, 32'h1c00_0000});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (es_to_ms_valid !== 1'b0) $display("FAIL add_drain got %0b exp 0", es_to_ms_valid); else n_pass++;
  endtask

  task automatic test_store_stall();
    instr_t t;
    int writes;
    writes = 0;
    t = mk(12'h001, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0100, 32'h0000_0024, 32'hdead_beef, 32'h1c00_0010);
    @(negedge clk);
    ds_to_es_valid = 1'b1; ds_to_es_bus = t; ms_allowin = 1'b1;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0; ms_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (data_sram_we != 4'h0) writes++;
      n_checks++;
      if (data_sram_we !== 4'h0 || data_sram_en !== 1'b1 || es_allowin !== 1'b0)
        $display("FAIL st_stall%0d got we=%h en=%0b allowin=%0b exp we=0 en=1 allowin=0",
                 i, data_sram_we, data_sram_en, es_allowin);
      else n_pass++;
      @(posedge clk); #1;
    end
    ms_allowin = 1'b1;
    #1;
    if (data_sram_we != 4'h0) writes++;
    n_checks++;
    if (data_sram_we !== 4'hf || data_sram_addr !== 32'h0000_0124 || data_sram_wdata !== 32'hdead_beef)
      $display("FAIL st_release got we=%h addr=%h wdata=%h exp f 00000124 deadbeef",
               data_sram_we, data_sram_addr, data_sram_wdata);
    else n_pass++;
    @(posedge clk); #1;
    if (data_sram_we != 4'h0) writes++;
    n_checks++;
    if (writes !== 1) $display("FAIL st_write_count got %0d exp 1", writes); else n_pass++;
    n_checks++;
    if (data_sram_en !== 1'b0) $display("FAIL st_after_en got %0b exp 0", data_sram_en); else n_pass++;
  endtask

  task automatic test_load();
    instr_t t;
    t = mk(12'h001, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_2000, 32'h0000_0008, 32'd0, 32'h1c00_0020);
    @(negedge clk);
    ds_to_es_valid = 1'b1; ds_to_es_bus = t; ms_allowin = 1'b1;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    n_checks++;
    if (es_ld_blk !== 1'b1 || data_sram_en !== 1'b1 || data_sram_we !== 4'h0)
      $display("FAIL ld_in_ex got blk=%0b en=%0b we=%h exp 1 1 0", es_ld_blk, data_sram_en, data_sram_we);
    else n_pass++;
    n_checks++;
    if (data_sram_addr !== 32'h0000_2008) $display("FAIL ld_addr got %h exp 00002008", data_sram_addr); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (es_ld_blk !== 1'b0 || es_to_ms_valid !== 1'b0 || data_sram_en !== 1'b0)
      $display("FAIL ld_bubble got blk=%0b valid=%0b en=%0b exp 0 0 0", es_ld_blk, es_to_ms_valid, data_sram_en);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ds_to_es_valid = 1'b1; ms_allowin = 1'b1;
    ds_to_es_bus = mk(12'h001, 1'b0, 1'b0, 1'b1, 5'd4, 32'd5, 32'd7, 32'd0, 32'h1c00_0030);
    @(posedge clk); #1;
    ds_to_es_bus = mk(12'h002, 1'b0, 1'b0, 1'b1, 5'd5, 32'd9, 32'd4, 32'd0, 32'h1c00_0034);
    n_checks++;
    if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[63:32] !== 32'd12)
      $display("FAIL b2b_first got v=%0b r=%0d exp 1 12", es_to_ms_valid, es_to_ms_bus[63:32]);
    else n_pass++;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    n_checks++;
    if (es_to_ms_valid !== 1'b1 || es_to_ms_bus[63:32] !== 32'd5 || es_fwd_dest !== 5'd5)
      $display("FAIL b2b_second got v=%0b r=%0d dest=%0d exp 1 5 5", es_to_ms_valid, es_to_ms_bus[63:32], es_fwd_dest);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    instr_t a;
    a = mk(12'h040, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_00f0, 32'h0000_000f, 32'd0, 32'h1c00_0040);
    @(negedge clk);
    ds_to_es_valid = 1'b1; ds_to_es_bus = a; ms_allowin = 1'b1;
    @(posedge clk); #1;
    ms_allowin = 1'b0;
    ds_to_es_bus = mk(12'h001, 1'b1, 1'b1, 1'b0, 5'd8, 32'd100, 32'd200, 32'd3, 32'h1c00_0044);
    #1;
    n_checks++;
    if (es_allowin !== 1'b0) $display("FAIL stall_allowin got %0b exp 0", es_allowin); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (es_to_ms_valid !== 1'b1 || es_to_ms_bus !== ms_ref(a))
      $display("FAIL stall_hold got v=%0b bus=%h exp 1 %h", es_to_ms_valid, es_to_ms_bus, ms_ref(a));
    else n_pass++;
    ms_allowin = 1'b1; ds_to_es_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_stall();
    int writes;
    writes = 0;
    @(negedge clk);
    ds_to_es_valid = 1'b1; ms_allowin = 1'b1;
    ds_to_es_bus = mk(12'h001, 1'b0, 1'b1, 1'b0, 5'd0, 32'h40, 32'h4, 32'h1234_5678, 32'h1c00_0050);
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0; ms_allowin = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (es_to_ms_valid !== 1'b0 || data_sram_en !== 1'b0 || data_sram_we !== 4'h0)
      $display("FAIL rst_mid got v=%0b en=%0b we=%h exp 0 0 0", es_to_ms_valid, data_sram_en, data_sram_we);
    else n_pass++;
    reset = 1'b0;
    ms_allowin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (data_sram_we != 4'h0 || data_sram_en != 1'b0) writes++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (writes !== 0) $display("FAIL rst_mid_nowrite got %0d accesses exp 0", writes); else n_pass++;
  endtask

  task automatic test_random();
    instr_t in_t;
    instr_t slot;
    logic   m_valid;
    logic   in_v;
    logic   accept;
    int     bad;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    m_valid = 1'b0;
    slot = '0;
    bad = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 400; c++) begin
      in_v = ($urandom_range(0, 3) != 0);
      in_t.op = 12'(1 << $urandom_range(0, 11));
      in_t.rfm = ($urandom_range(0, 3) == 0);
      in_t.mwe = ($urandom_range(0, 3) == 0);
      in_t.grwe = $urandom_range(0, 1) == 1;
      in_t.dest = 5'($urandom);
      in_t.s1 = $urandom;
      in_t.s2 = $urandom;
      in_t.rkd = $urandom;
      in_t.pc = $urandom;
      ds_to_es_valid = in_v;
      ds_to_es_bus = in_t;
      ms_allowin = ($urandom_range(0, 2) != 0);
      #1;
      accept = !m_valid || ms_allowin;
      n_checks++;
      if (es_allowin !== accept || es_to_ms_valid !== m_valid) begin
        $display("FAIL rnd_hs c=%0d got allowin=%0b v=%0b exp %0b %0b", c, es_allowin, es_to_ms_valid, accept, m_valid);
        bad++;
      end else n_pass++;
      n_checks++;
      if (data_sram_en !== (m_valid && (slot.rfm || slot.mwe)) ||
          data_sram_we !== {4{m_valid && slot.mwe && ms_allowin}} ||
          es_ld_blk !== (m_valid && slot.rfm) || es_fwd_valid !== (m_valid && slot.grwe))
        $display("FAIL rnd_ctl c=%0d got en=%0b we=%h blk=%0b fwd=%0b", c, data_sram_en, data_sram_we, es_ld_blk, es_fwd_valid);
      else n_pass++;
      if (m_valid) begin
        n_checks++;
        if (es_to_ms_bus !== ms_ref(slot) || data_sram_addr !== alu_ref(slot.op, slot.s1, slot.s2) ||
            data_sram_wdata !== slot.rkd || es_fwd_dest !== slot.dest || es_fwd_data !== alu_ref(slot.op, slot.s1, slot.s2))
          $display("FAIL rnd_data c=%0d got bus=%h exp %h", c, es_to_ms_bus, ms_ref(slot));
        else n_pass++;
      end
      @(posedge clk);
      if (accept) begin
        m_valid = in_v;
        if (in_v) slot = in_t;
      end
      #1;
      if (bad > 20) break;
    end
    ds_to_es_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_store_stall();
    test_load();
    test_back_to_back();
    test_stall();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Parameter DS_TO_ES_W, default 148: width of the ID-to-EX bus.
REQ-002 Parameter ES_TO_MS_W, default 71: width of the EX-to-MEM bus.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ms_allowin  in  1  MEM stage can accept an instruction this cycle.
REQ-006 es_allowin  out  1  EX stage can accept an instruction this cycle.
REQ-007 ds_to_es_valid  in  1  ID stage presents a valid instruction.
REQ-008 ds_to_es_bus  in  DS_TO_ES_W  = {alu_op[11:0], res_from_mem, mem_we, gr_we, dest[4:0], alu_src1[31:0], alu_src2[31:0], rkd_value[31:0], pc[31:0]}, MSB first.
REQ-009 es_to_ms_valid  out  1  EX stage presents a valid instruction to MEM.
REQ-010 es_to_ms_bus  out  ES_TO_MS_W  = {res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}, MSB first.
REQ-011 data_sram_en  out  1  data SRAM access enable.
REQ-012 data_sram_we  out  4  data SRAM byte write strobes.
REQ-013 data_sram_addr  out  32  data SRAM byte address.
REQ-014 data_sram_wdata  out  32  data SRAM write data.
REQ-015 es_fwd_valid  out  1  EX holds a valid instruction that writes a GPR.
REQ-016 es_fwd_dest  out  5  destination register of that instruction.
REQ-017 es_fwd_data  out  32  ALU result, used for bypass.
REQ-018 es_ld_blk  out  1  EX holds a valid load; ID must stall on a matching source register.

Function
REQ-019 The stage SHALL hold one instruction: valid flag es_valid plus a DS_TO_ES_W-bit payload register es_bus.
REQ-020 es_ready_go SHALL be constant 1 (single-cycle execute).
REQ-021 es_allowin SHALL equal !es_valid | (es_ready_go & ms_allowin).
REQ-022 es_to_ms_valid SHALL equal es_valid & es_ready_go.
REQ-023 When es_allowin=1, es_valid SHALL load ds_to_es_valid on the clock edge.
REQ-024 es_bus SHALL load ds_to_es_bus only when ds_to_es_valid & es_allowin; otherwise it SHALL hold.
REQ-025 When es_allowin=0 (stall), es_valid and es_bus SHALL hold unchanged.
REQ-026 The stage SHALL drive the existing alu module from es_bus: alu_op, alu_src1, alu_src2; the result is alu_result.
REQ-027 Latency: an instruction accepted at edge N SHALL appear on es_to_ms_bus from edge N to the edge it is accepted by MEM.
REQ-028 data_sram_en SHALL equal es_valid & (res_from_mem | mem_we).
REQ-029 data_sram_we SHALL equal {4{es_valid & mem_we & ms_allowin}}; a store stalled by MEM SHALL NOT write until the advancing cycle, so exactly one write occurs per store.
REQ-030 data_sram_addr SHALL equal alu_result; data_sram_wdata SHALL equal rkd_value.
REQ-031 es_fwd_valid SHALL equal es_valid & gr_we; es_fwd_dest SHALL equal dest; es_fwd_data SHALL equal alu_result.
REQ-032 es_ld_blk SHALL equal es_valid & res_from_mem.
REQ-033 When ds_to_es_valid=0 and es_allowin=1, es_valid SHALL clear (bubble) and es_bus SHALL hold; no SRAM access SHALL be issued.
REQ-034 If the stage drains and refills on the same edge (es_valid=1, ms_allowin=1, ds_to_es_valid=1), the new payload SHALL replace the old with no bubble.

Reset
REQ-035 Reset SHALL force es_valid=0 and es_bus=0 immediately, without waiting for a clock edge.
REQ-036 During and after reset: es_to_ms_valid=0, es_allowin=1, data_sram_en=0, data_sram_we=4'h0, es_fwd_valid=0, es_ld_blk=0.
REQ-037 If reset asserts mid-stall, the held instruction SHALL be discarded and SHALL NOT write SRAM.

Verification
REQ-038 ADD: alu_op=12'h001, src1=5, src2=7, gr_we=1, dest=3, ms_allowin=1 -> after one edge, es_to_ms_valid=1, alu_result=12, es_fwd_valid=1, es_fwd_dest=3.
REQ-039 Store with ms_allowin=0 for 3 cycles, then 1 -> data_sram_we=4'hf in the release cycle only, addr=src1+src2, wdata=rkd_value.
REQ-040 Load in EX -> es_ld_blk=1, data_sram_en=1, data_sram_we=0; next edge with ds_to_es_valid=0 -> es_ld_blk=0, es_valid=0.
REQ-041 Back-to-back ADD then SUB (12'h002, 9-4) with ms_allowin=1 -> results 12, then 5 on consecutive cycles, no bubble.
REQ-042 Stall: ms_allowin=0 with es_valid=1 -> es_allowin=0, the new ds_to_es_bus is ignored, and the output bus stays stable.
REQ-043 Reset pulse between edges while a store is stalled -> es_valid=0 at once, with no SRAM write afterwards.
